note_player: RTL
================

Name: note_player

Overview:
- Per-channel consumer of the pattern sequencer's note stream. Sits directly downstream of it.
- Requests notes with a single-cycle strobe and latches pitch, length and instrument.
- Converts pitch to an oscillator phase increment through a 1-cycle-latency frequency ROM.
- Times each note in frame ticks and drives gate, volume (decay envelope), phase increment and instrument to the oscillator/mixer stage.

Parameters:
TICKS_PER_STEP, 6, frame ticks per note-length unit; legal range 1..255
PHASE_WIDTH, 16, width of phase increment and frequency ROM data

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_enable  in  1  play enable (level)
i_tick  in  1  frame tick, single-cycle pulse
o_note_stb  out  1  note request to sequencer, single-cycle pulse
i_note_valid  in  1  sequencer note valid, single-cycle pulse
i_note_pitch  in  6  note pitch; 0 = rest
i_note_len  in  5  length in steps; 0 = 32 steps
i_note_instrument  in  4  decay rate; 0 = sustain
o_freq_addr  out  6  frequency ROM address
i_freq_data  in  PHASE_WIDTH  ROM data, valid the cycle after the address
o_gate  out  1  note sounding
o_phase_inc  out  PHASE_WIDTH  oscillator phase increment
o_volume  out  4  envelope level
o_instrument  out  4  current instrument

Behaviour:
- Reset: state IDLE. All outputs 0. All internal counters 0.
- States: IDLE, REQUEST, WAIT_NOTE, FREQ_ADDR, FREQ_READ, PLAY.
- IDLE: if i_enable, go to REQUEST next cycle.
- REQUEST: o_note_stb=1 for this cycle only; o_gate=0 (retrigger). Go to WAIT_NOTE.
- WAIT_NOTE: wait indefinitely for i_note_valid.
  - On valid: latch pitch, len and instrument. Go to FREQ_ADDR, or to IDLE if i_enable=0.
  - A valid arriving in any other state is ignored.
- FREQ_ADDR: o_freq_addr = latched pitch. o_freq_addr is 0 in every other state. Go to FREQ_READ.
- FREQ_READ: load outputs and counters, then go to PLAY.
  - o_phase_inc = (pitch==0) ? 0 : i_freq_data.
  - o_gate = (pitch!=0).
  - o_volume = 15.
  - o_instrument = latched instrument.
  - steps_left = (len==0) ? 32 (6-bit) : len.
  - tick_cnt = 0, decay_cnt = 0.
- PLAY: i_tick is counted only in PLAY; ticks in other states are dropped.
  - Each i_tick: if tick_cnt == TICKS_PER_STEP-1, then tick_cnt=0 and steps_left--; else tick_cnt++.
  - If a tick brings steps_left to 0, go to REQUEST next cycle.
  - Envelope, on each i_tick with instrument != 0: if decay_cnt == instrument-1, then decay_cnt=0 and volume decrements, saturating at 0; else decay_cnt++.
  - Instrument 0 holds volume at 15.
  - If i_enable=0 in PLAY: go to IDLE next cycle and clear o_gate and o_volume. o_phase_inc and o_instrument hold.
- Latency:
  - Stb to first gate = sequencer latency + 3 cycles; with the standard sequencer, valid arrives 4 cycles after stb.
  - Note duration = steps × TICKS_PER_STEP ticks, measured from the first tick seen in PLAY.
- Rest notes time normally with gate=0 and phase_inc=0.
- Reset mid-operation: immediate return to IDLE with all outputs 0. A sequencer valid already in flight is ignored.

Test Plan:
- Reset, enable=1 → o_note_stb pulses exactly once. Sequencer returns pitch=10, len=2, instr=0; ROM[10]=0x1234 → o_freq_addr=10 for one cycle, then gate=1, phase_inc=0x1234, volume=15.
- TICKS_PER_STEP=6, len=2 → gate stays high for exactly 12 ticks. Next o_note_stb is issued the cycle after the 12th tick, and gate drops in that REQUEST cycle.
- len=0 → note lasts 32×6=192 ticks.
- pitch=0 → gate=0, phase_inc=0 for the full duration, then a normal re-request.
- instr=3 → volume steps 15,14,13,… every 3 ticks and saturates at 0 after 45 ticks.
- Enable dropped in PLAY → IDLE next cycle, gate=0, volume=0. Enable dropped in WAIT_NOTE → valid is consumed, then IDLE. Ticks before the first PLAY cycle are not counted. i_rst mid-note → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/note_player_if.sv
// Note-player bus bundle: sequencer note handshake, frequency ROM port and oscillator/mixer outputs.
// The master side is the note player; the slave side is the sequencer, the ROM and the mixer.
`timescale 1ns/1ps

interface note_player_if #(
    parameter int PHASE_WIDTH = 16
);
    logic                   o_note_stb;
    logic                   i_note_valid;
    logic [5:0]             i_note_pitch;
    logic [4:0]             i_note_len;
    logic [3:0]             i_note_instrument;
    logic [5:0]             o_freq_addr;
    logic [PHASE_WIDTH-1:0] i_freq_data;
    logic                   o_gate;
    logic [PHASE_WIDTH-1:0] o_phase_inc;
    logic [3:0]             o_volume;
    logic [3:0]             o_instrument;

    modport master (
        output o_note_stb,
        input  i_note_valid,
        input  i_note_pitch,
        input  i_note_len,
        input  i_note_instrument,
        output o_freq_addr,
        input  i_freq_data,
        output o_gate,
        output o_phase_inc,
        output o_volume,
        output o_instrument
    );

    modport slave (
        input  o_note_stb,
        output i_note_valid,
        output i_note_pitch,
        output i_note_len,
        output i_note_instrument,
        input  o_freq_addr,
        output i_freq_data,
        input  o_gate,
        input  o_phase_inc,
        input  o_volume,
        input  o_instrument
    );
endinterface

// File: rtl/note_player.sv
// Per-channel note player: requests notes from the sequencer, looks up the phase increment,
// times each note in frame ticks and applies a linear decay envelope.
`timescale 1ns/1ps

module note_player #(
    parameter int TICKS_PER_STEP = 6,
    parameter int PHASE_WIDTH    = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_enable,
    input  logic          i_tick,
    note_player_if.master bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQUEST   = 3'd1,
        WAIT_NOTE = 3'd2,
        FREQ_ADDR = 3'd3,
        FREQ_READ = 3'd4,
        PLAY      = 3'd5
    } state_t;

    localparam logic [7:0] TICK_LAST = 8'(TICKS_PER_STEP - 1);

    state_t                 state_q, state_d;
    logic                   stb_q, stb_d;
    logic [5:0]             freq_addr_q, freq_addr_d;
    logic                   gate_q, gate_d;
    logic [PHASE_WIDTH-1:0] phase_inc_q, phase_inc_d;
    logic [3:0]             volume_q, volume_d;
    logic [3:0]             instrument_q, instrument_d;

    logic [5:0]             pitch_q, pitch_d;
    logic [4:0]             len_q, len_d;
    logic [3:0]             instr_q, instr_d;
    logic [5:0]             steps_left_q, steps_left_d;
    logic [7:0]             tick_cnt_q, tick_cnt_d;
    logic [3:0]             decay_cnt_q, decay_cnt_d;

    logic                   step_wrap;
    logic                   decay_wrap;

    assign step_wrap  = (tick_cnt_q == TICK_LAST);
    assign decay_wrap = (decay_cnt_q == (instrument_q - 4'd1));

    // Outputs are registered, so each one is computed from the state being entered:
    // the strobe and the ROM address are high exactly while REQUEST / FREQ_ADDR is current.
    always_comb begin
        state_d      = state_q;
        stb_d        = 1'b0;
        freq_addr_d  = 6'd0;
        gate_d       = gate_q;
        phase_inc_d  = phase_inc_q;
        volume_d     = volume_q;
        instrument_d = instrument_q;
        pitch_d      = pitch_q;
        len_d        = len_q;
        instr_d      = instr_q;
        steps_left_d = steps_left_q;
        tick_cnt_d   = tick_cnt_q;
        decay_cnt_d  = decay_cnt_q;

        case (state_q)
            IDLE: begin
                if (i_enable) begin
                    state_d = REQUEST;
                    stb_d   = 1'b1;
                    gate_d  = 1'b0;
                end
            end

            REQUEST: begin
                state_d = WAIT_NOTE;
            end

            WAIT_NOTE: begin
                if (bus.i_note_valid) begin
                    pitch_d = bus.i_note_pitch;
                    len_d   = bus.i_note_len;
                    instr_d = bus.i_note_instrument;
                    if (i_enable) begin
                        state_d     = FREQ_ADDR;
                        freq_addr_d = bus.i_note_pitch;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            FREQ_ADDR: begin
                state_d = FREQ_READ;
            end

            FREQ_READ: begin
                phase_inc_d  = (pitch_q == 6'd0) ? '0 : bus.i_freq_data;
                gate_d       = (pitch_q != 6'd0);
                volume_d     = 4'd15;
                instrument_d = instr_q;
                steps_left_d = (len_q == 5'd0) ? 6'd32 : {1'b0, len_q};
                tick_cnt_d   = 8'd0;
                decay_cnt_d  = 4'd0;
                state_d      = PLAY;
            end

            PLAY: begin
                if (!i_enable) begin
                    state_d  = IDLE;
                    gate_d   = 1'b0;
                    volume_d = 4'd0;
                end else if (i_tick) begin
                    if (step_wrap) begin
                        tick_cnt_d   = 8'd0;
                        steps_left_d = steps_left_q - 6'd1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 8'd1;
                    end

                    // Instrument 0 means sustain: the envelope never moves off 15.
                    if (instrument_q != 4'd0) begin
                        if (decay_wrap) begin
                            decay_cnt_d = 4'd0;
                            volume_d    = (volume_q == 4'd0) ? 4'd0 : volume_q - 4'd1;
                        end else begin
                            decay_cnt_d = decay_cnt_q + 4'd1;
                        end
                    end

                    if (step_wrap && (steps_left_q == 6'd1)) begin
                        state_d = REQUEST;
                        stb_d   = 1'b1;
                        gate_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            stb_q        <= 1'b0;
            freq_addr_q  <= 6'd0;
            gate_q       <= 1'b0;
            phase_inc_q  <= '0;
            volume_q     <= 4'd0;
            instrument_q <= 4'd0;
            pitch_q      <= 6'd0;
            len_q        <= 5'd0;
            instr_q      <= 4'd0;
            steps_left_q <= 6'd0;
            tick_cnt_q   <= 8'd0;
            decay_cnt_q  <= 4'd0;
        end else begin
            state_q      <= state_d;
            stb_q        <= stb_d;
            freq_addr_q  <= freq_addr_d;
            gate_q       <= gate_d;
            phase_inc_q  <= phase_inc_d;
            volume_q     <= volume_d;
            instrument_q <= instrument_d;
            pitch_q      <= pitch_d;
            len_q        <= len_d;
            instr_q      <= instr_d;
            steps_left_q <= steps_left_d;
            tick_cnt_q   <= tick_cnt_d;
            decay_cnt_q  <= decay_cnt_d;
        end
    end

    assign bus.o_note_stb   = stb_q;
    assign bus.o_freq_addr  = freq_addr_q;
    assign bus.o_gate       = gate_q;
    assign bus.o_phase_inc  = phase_inc_q;
    assign bus.o_volume     = volume_q;
    assign bus.o_instrument = instrument_q;

endmodule
